// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S sample-FIFO scheduling logic: state encoding,
// default FIFO geometry and lag thresholds, and a saturating counter helper.
package i2s_pkg;

    localparam int I2S_IDX_W      = 3;
    localparam int I2S_LAG_TGT    = 4;
    localparam int I2S_LAG_MIN    = 2;
    localparam int I2S_LAG_MAX    = 6;
    localparam int I2S_SLIP_LIMIT = 4;
    localparam int I2S_FRAME_LEN  = 166;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_RESYNC  = 2'd2
    } state_t;

    // Status counters stick at 255 rather than wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value, input logic en);
        return (en && (value != 8'hFF)) ? value + 8'd1 : value;
    endfunction

endpackage

// File: rtl/i2s_gray_sync.sv
// Two-flop synchronizer for a Gray-coded pointer followed by combinational
// Gray-to-binary conversion.
module i2s_gray_sync #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] gray_in,
    output logic [W-1:0] bin_out
);

    logic [W-1:0] s1_reg;
    logic [W-1:0] s2_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= gray_in;
            s2_reg <= s1_reg;
        end
    end

    // Each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_g2b
            assign bin_out[gi] = ^s2_reg[W-1:gi];
        end
    endgenerate

endmodule

// File: rtl/i2s_fifo_rd_sched.sv
// Read-side slot scheduler for the 8-slot I2S FIFO: keeps writer-to-reader lag
// near a target by slipping or repeating slots, re-centres on underrun.
module i2s_fifo_rd_sched
    import i2s_pkg::*;
#(
    parameter int IDX_W      = I2S_IDX_W,
    parameter int LAG_TGT    = I2S_LAG_TGT,
    parameter int LAG_MIN    = I2S_LAG_MIN,
    parameter int LAG_MAX    = I2S_LAG_MAX,
    parameter int SLIP_LIMIT = I2S_SLIP_LIMIT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] wr_idx_gray,
    input  logic             frame_tick,
    input  logic             clr_stat,
    output logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [1:0]       state,
    output logic [7:0]       slip_fwd_cnt,
    output logic [7:0]       slip_back_cnt,
    output logic [7:0]       resync_cnt,
    output logic             err_unf
);

    localparam int SC_W = $clog2(SLIP_LIMIT + 1);
    localparam logic [IDX_W-1:0] LAG_TGT_I = IDX_W'(LAG_TGT);
    localparam logic [IDX_W-1:0] LAG_MIN_I = IDX_W'(LAG_MIN);
    localparam logic [IDX_W-1:0] LAG_MAX_I = IDX_W'(LAG_MAX);
    localparam logic [SC_W-1:0]  SLIP_LAST = SC_W'(SLIP_LIMIT - 1);

    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] lag;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] rd_reg, rd_next;
    logic [IDX_W-1:0] prev_wr_reg, prev_wr_next;
    logic             valid_reg, valid_next;
    logic [SC_W-1:0]  slip_reg, slip_next;
    logic             err_reg;
    logic             set_err;

    // Counter index 0: forward slips, 1: repeats, 2: resync entries.
    logic [7:0]       cnt_reg [3];
    logic [2:0]       cnt_inc;

    i2s_gray_sync #(.W(IDX_W)) u_wr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .gray_in (wr_idx_gray),
        .bin_out (wr_idx)
    );

    assign lag = wr_idx - rd_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_ACQUIRE;
            rd_reg      <= '0;
            prev_wr_reg <= '0;
            valid_reg   <= 1'b0;
            slip_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            rd_reg      <= rd_next;
            prev_wr_reg <= prev_wr_next;
            valid_reg   <= valid_next;
            slip_reg    <= slip_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rd_next      = rd_reg;
        prev_wr_next = prev_wr_reg;
        valid_next   = valid_reg;
        slip_next    = slip_reg;
        set_err      = 1'b0;
        cnt_inc      = 3'b000;
        if (frame_tick) begin
            prev_wr_next = wr_idx;
            case (state_reg)
                ST_ACQUIRE: begin
                    if (wr_idx != prev_wr_reg) begin
                        rd_next    = wr_idx - LAG_TGT_I;
                        valid_next = 1'b1;
                        state_next = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (lag == '0) begin
                        set_err    = 1'b1;
                        valid_next = 1'b0;
                        state_next = ST_RESYNC;
                        slip_next  = '0;
                        cnt_inc[2] = 1'b1;
                    end else if ((lag > LAG_MAX_I) || (lag < LAG_MIN_I)) begin
                        // The slip that would reach the limit resyncs instead.
                        if (slip_reg == SLIP_LAST) begin
                            valid_next = 1'b0;
                            state_next = ST_RESYNC;
                            slip_next  = '0;
                            cnt_inc[2] = 1'b1;
                        end else begin
                            slip_next = slip_reg + SC_W'(1);
                            if (lag > LAG_MAX_I) begin
                                rd_next    = rd_reg + IDX_W'(2);
                                cnt_inc[0] = 1'b1;
                            end else begin
                                cnt_inc[1] = 1'b1;
                            end
                        end
                    end else begin
                        rd_next   = rd_reg + IDX_W'(1);
                        slip_next = '0;
                    end
                end
                ST_RESYNC: begin
                    rd_next    = wr_idx - LAG_TGT_I;
                    valid_next = 1'b1;
                    state_next = ST_TRACK;
                end
                default: begin
                    state_next = ST_ACQUIRE;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg[gi] <= '0;
                end else if (clr_stat) begin
                    cnt_reg[gi] <= '0;
                end else begin
                    cnt_reg[gi] <= sat_inc(cnt_reg[gi], cnt_inc[gi]);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_reg <= 1'b0;
        end else if (clr_stat) begin
            err_reg <= 1'b0;
        end else if (set_err) begin
            err_reg <= 1'b1;
        end
    end

    assign rd_idx        = rd_reg;
    assign rd_valid      = valid_reg;
    assign state         = state_reg;
    assign slip_fwd_cnt  = cnt_reg[0];
    assign slip_back_cnt = cnt_reg[1];
    assign resync_cnt    = cnt_reg[2];
    assign err_unf       = err_reg;

endmodule

// File: tb/tb_i2s_fifo_rd_sched.sv
// Directed bench for i2s_fifo_rd_sched: a behavioural lag model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_i2s_fifo_rd_sched;

    localparam int TGT  = 4;
    localparam int LMIN = 2;
    localparam int LMAX = 6;
    localparam int SLIM = 2;

    logic       clk;
    logic       reset_n;
    logic [2:0] wr_idx_gray;
    logic       frame_tick;
    logic       clr_stat;
    logic [2:0] rd_idx;
    logic       rd_valid;
    logic [1:0] state;
    logic [7:0] slip_fwd_cnt;
    logic [7:0] slip_back_cnt;
    logic [7:0] resync_cnt;
    logic       err_unf;

    logic [2:0] wr_bin;

    int n_vec = 0;
    int n_bad = 0;

    i2s_fifo_rd_sched #(.SLIP_LIMIT(SLIM)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wr_idx_gray   (wr_idx_gray),
        .frame_tick    (frame_tick),
        .clr_stat      (clr_stat),
        .rd_idx        (rd_idx),
        .rd_valid      (rd_valid),
        .state         (state),
        .slip_fwd_cnt  (slip_fwd_cnt),
        .slip_back_cnt (slip_back_cnt),
        .resync_cnt    (resync_cnt),
        .err_unf       (err_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: writer index seen two clocks late, lag rules on ticks.
    int m_rd, m_valid, m_state, m_fwd, m_back, m_rsy, m_err, m_prev, m_slip;
    logic [2:0] d1, d2;

    always @(posedge clk or negedge reset_n) begin : model
        int w, lag, ef, eb, er, ee;
        if (!reset_n) begin
            m_rd <= 0; m_valid <= 0; m_state <= 0; m_fwd <= 0; m_back <= 0;
            m_rsy <= 0; m_err <= 0; m_prev <= 0; m_slip <= 0;
            d1 <= '0; d2 <= '0;
        end else begin
            d1 <= wr_bin;
            d2 <= d1;
            ef = 0; eb = 0; er = 0; ee = 0;
            if (frame_tick) begin
                w = int'(d2);
                m_prev <= w;
                lag = (w - m_rd + 8) % 8;
                if (m_state == 0) begin
                    if (w != m_prev) begin
                        m_rd <= (w - TGT + 8) % 8; m_valid <= 1; m_state <= 1;
                    end
                end else if (m_state == 2) begin
                    m_rd <= (w - TGT + 8) % 8; m_valid <= 1; m_state <= 1;
                end else if (lag == 0) begin
                    ee = 1; er = 1; m_valid <= 0; m_state <= 2; m_slip <= 0;
                end else if (lag > LMAX || lag < LMIN) begin
                    if (m_slip + 1 == SLIM) begin
                        er = 1; m_valid <= 0; m_state <= 2; m_slip <= 0;
                    end else begin
                        m_slip <= m_slip + 1;
                        if (lag > LMAX) begin
                            m_rd <= (m_rd + 2) % 8; ef = 1;
                        end else begin
                            eb = 1;
                        end
                    end
                end else begin
                    m_rd <= (m_rd + 1) % 8; m_slip <= 0;
                end
            end
            if (clr_stat) begin
                m_fwd <= 0; m_back <= 0; m_rsy <= 0; m_err <= 0;
            end else begin
                m_fwd  <= (m_fwd + ef > 255) ? 255 : m_fwd + ef;
                m_back <= (m_back + eb > 255) ? 255 : m_back + eb;
                m_rsy  <= (m_rsy + er > 255) ? 255 : m_rsy + er;
                m_err  <= m_err | ee;
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_rd_idx", int'(rd_idx), m_rd);
        check("cyc_rd_valid", int'(rd_valid), m_valid);
        check("cyc_state", int'(state), m_state);
        check("cyc_slip_fwd", int'(slip_fwd_cnt), m_fwd);
        check("cyc_slip_back", int'(slip_back_cnt), m_back);
        check("cyc_resync", int'(resync_cnt), m_rsy);
        check("cyc_err_unf", int'(err_unf), m_err);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int v);
        wr_bin      = 3'(v);
        wr_idx_gray = 3'(v) ^ (3'(v) >> 1);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        $display("tick wr=%0d rd=%0d valid=%0d state=%0d fwd=%0d back=%0d rsy=%0d err=%0d",
                 wr_bin, rd_idx, rd_valid, state, slip_fwd_cnt, slip_back_cnt,
                 resync_cnt, err_unf);
    endtask

    // New writer index, let it cross the synchronizer, then decide on it.
    task automatic step(input int v);
        set_wr(v);
        cyc(2);
        tick();
    endtask

    initial begin
        int r, w;
        reset_n = 1'b0; frame_tick = 1'b0; clr_stat = 1'b0;
        set_wr(0);
        cyc(3);
        check("rst_rd_idx", int'(rd_idx), 0);
        check("rst_valid", int'(rd_valid), 0);
        check("rst_state", int'(state), 0);
        reset_n = 1'b1;
        cyc(2);

        tick();
        check("acq_idle_state", int'(state), 0);
        step(1);
        check("acq_rd_idx", int'(rd_idx), 5);
        check("acq_valid", int'(rd_valid), 1);
        check("acq_state", int'(state), 1);

        for (int v = 2; v <= 5; v++) step(v);
        check("track_rd_idx", int'(rd_idx), 1);
        check("track_fwd", int'(slip_fwd_cnt), 0);
        check("track_rsy", int'(resync_cnt), 0);

        step(7);
        check("fast_rd_idx", int'(rd_idx), 2);
        step(1);
        check("fwd_rd_idx", int'(rd_idx), 4);
        check("fwd_cnt", int'(slip_fwd_cnt), 1);
        step(2);
        check("after_fwd_rd", int'(rd_idx), 5);

        for (int i = 0; i < 4; i++) tick();
        check("frozen_rd_idx", int'(rd_idx), 1);
        tick();
        check("repeat_rd_idx", int'(rd_idx), 1);
        check("repeat_back", int'(slip_back_cnt), 1);
        tick();
        check("limit_state", int'(state), 2);
        check("limit_valid", int'(rd_valid), 0);
        check("limit_rsy", int'(resync_cnt), 1);
        step(3);
        check("recentre_rd", int'(rd_idx), 7);
        check("recentre_state", int'(state), 1);

        step(7);
        check("unf_err", int'(err_unf), 1);
        check("unf_valid", int'(rd_valid), 0);
        check("unf_rsy", int'(resync_cnt), 2);
        tick();
        check("unf_recentre_rd", int'(rd_idx), 3);

        set_wr(2);
        cyc(2);
        clr_stat = 1'b1;
        tick();
        clr_stat = 1'b0;
        check("clr_rd_idx", int'(rd_idx), 5);
        check("clr_fwd", int'(slip_fwd_cnt), 0);
        check("clr_rsy", int'(resync_cnt), 0);
        check("clr_err", int'(err_unf), 0);
        step(3);
        check("post_clr_rd", int'(rd_idx), 6);

        r = 6;
        w = 0;
        for (int i = 0; i < 260; i++) begin
            w = r;
            step(w);
            tick();
            r = (w - TGT + 8) % 8;
        end
        check("sat_rsy", int'(resync_cnt), 255);
        check("sat_err", int'(err_unf), 1);
        check("sat_rd_idx", int'(rd_idx), 6);

        #2;
        reset_n = 1'b0;
        #1;
        check("arst_rd_idx", int'(rd_idx), 0);
        check("arst_valid", int'(rd_valid), 0);
        check("arst_state", int'(state), 0);
        check("arst_rsy", int'(resync_cnt), 0);
        check("arst_err", int'(err_unf), 0);
        cyc(1);
        reset_n = 1'b1;
        step(w);
        check("reacq_rd_idx", int'(rd_idx), 6);
        check("reacq_state", int'(state), 1);
        check("reacq_valid", int'(rd_valid), 1);

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
